// File: rtl/btn_event_if.sv
// Button-event bundle: debounced level into the decoder, event pulses and count out.
interface btn_event_if;
  localparam int unsigned EVT_W = 8;

  logic             btn_deb;
  logic             click_pulse;
  logic             double_pulse;
  logic             long_pulse;
  logic             repeat_pulse;
  logic             busy;
  logic [EVT_W-1:0] event_count;

  // master drives the button level, slave is the decoder producing events
  modport master (
    output btn_deb,
    input  click_pulse, double_pulse, long_pulse, repeat_pulse, busy, event_count
  );

  modport slave (
    input  btn_deb,
    output click_pulse, double_pulse, long_pulse, repeat_pulse, busy, event_count
  );
endinterface

// File: rtl/btn_event_decoder.sv
// Classifies debounced button presses into click / double-click / long-press / auto-repeat
// one-tick pulses on clk_5ms, and keeps a running mod-256 count of emitted events.
module btn_event_decoder #(
  parameter int unsigned LONG_TICKS   = 200,
  parameter int unsigned DCLICK_TICKS = 60,
  parameter int unsigned REPEAT_TICKS = 40,
  parameter int unsigned CNT_W        = 9
) (
  input  logic        clk_5ms,
  input  logic        rst,
  btn_event_if.slave  bus
);

  localparam int unsigned EVT_W = 8;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_M  = CNT_W'(DCLICK_TICKS);
  localparam logic [CNT_W-1:0] REPEAT_M1 = CNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_LONG_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             click_q, click_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             busy_q, busy_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             rise_c, fall_c;

  assign rise_c = bus.btn_deb & ~btn_q;
  assign fall_c = ~bus.btn_deb & btn_q;

  // btn_q resets high so a button held through reset is ignored until re-pressed
  always_ff @(posedge clk_5ms or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      btn_q    <= 1'b1;
      click_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
      evt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_q    <= bus.btn_deb;
      click_q  <= click_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
      evt_q    <= evt_d;
    end
  end

  // Next-state, shared tick counter and event decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    click_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise_c) begin
          state_d = S_PRESS1;
          cnt_d   = CNT_ONE;
        end
      end
      S_PRESS1: begin
        if (fall_c) begin
          state_d = S_WAIT2;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == LONG_M1) begin
          long_d  = 1'b1;
          state_d = S_LONG_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT2: begin
        if (rise_c) begin
          state_d = S_PRESS2;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == DCLICK_M) begin
          click_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESS2: begin
        if (fall_c) begin
          double_d = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == LONG_M1) begin
          // first click is committed, second press turns into a long press
          click_d = 1'b1;
          long_d  = 1'b1;
          state_d = S_LONG_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LONG_HOLD: begin
        if (fall_c) begin
          state_d = S_IDLE;
        end else if (cnt_q == REPEAT_M1) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    evt_d  = evt_q + EVT_W'(click_d) + EVT_W'(double_d) + EVT_W'(long_d) + EVT_W'(repeat_d);
  end

  assign bus.click_pulse  = click_q;
  assign bus.double_pulse = double_q;
  assign bus.long_pulse   = long_q;
  assign bus.repeat_pulse = repeat_q;
  assign bus.busy         = busy_q;
  assign bus.event_count  = evt_q;

endmodule
